// File: rtl/bridge_pkg.sv
// Shared constants for the CPU data-side 1-to-N bridge.
package bridge_pkg;

   localparam logic [1:0] SZ_BYTE = 2'd0;
   localparam logic [1:0] SZ_HALF = 2'd1;
   localparam logic [1:0] SZ_WORD = 2'd2;

   localparam int unsigned AW_DEF = 32;
   localparam int unsigned DW_DEF = 32;

   // Pointer width for a ring of 'depth' entries; never below one bit.
   function automatic int unsigned ptr_w(input int unsigned depth);
      return (depth > 1) ? $clog2(depth) : 1;
   endfunction

endpackage

// File: rtl/bridge_id_fifo.sv
// Small FIFO of slave ids for outstanding transactions; exposes both the oldest and newest entry.
module bridge_id_fifo
   import bridge_pkg::*;
#(
   parameter int unsigned WIDTH = 1,
   parameter int unsigned DEPTH = 4
) (
   input  logic                           clk,
   input  logic                           resetn,
   input  logic                           push,
   input  logic                           pop,
   input  logic [WIDTH-1:0]               din,
   output logic [WIDTH-1:0]               head,
   output logic [WIDTH-1:0]               last,
   output logic                           full,
   output logic                           empty,
   output logic [$clog2(DEPTH+1)-1:0]     count
);

   localparam int unsigned PW = ptr_w(DEPTH);
   localparam int unsigned CW = $clog2(DEPTH + 1);
   localparam logic [PW-1:0] PTR_MAX = PW'(DEPTH - 1);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [PW-1:0]    rd_ptr;
   logic [PW-1:0]    wr_ptr;
   logic [PW-1:0]    last_ptr;
   logic             do_push;
   logic             do_pop;

   function automatic logic [PW-1:0] inc(input logic [PW-1:0] p);
      return (p == PTR_MAX) ? '0 : p + PW'(1);
   endfunction

   assign full     = (count == CW'(DEPTH));
   assign empty    = (count == '0);
   assign do_push  = push & ~full;
   assign do_pop   = pop & ~empty;
   assign last_ptr = (wr_ptr == '0) ? PTR_MAX : wr_ptr - PW'(1);
   assign head     = mem[rd_ptr];
   assign last     = mem[last_ptr];

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         rd_ptr <= '0;
         wr_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) wr_ptr <= inc(wr_ptr);
         if (do_pop)  rd_ptr <= inc(rd_ptr);
         case ({do_push, do_pop})
            2'b10:   count <= count + CW'(1);
            2'b01:   count <= count - CW'(1);
            default: count <= count;
         endcase
      end
   end

   // Storage carries no reset: entries are only read while counted valid.
   always_ff @(posedge clk) begin
      if (do_push) mem[wr_ptr] <= din;
   end

endmodule

// File: rtl/bridge_1xn.sv
// 1-to-N router for the SRAM-like data bus; responses return in order from the slave that took each request.
module bridge_1xn
   import bridge_pkg::*;
#(
   parameter int unsigned N_SLV     = 2,
   parameter int unsigned SEL_W     = 1,
   parameter int unsigned MAX_OUTST = 4,
   parameter int unsigned AW        = AW_DEF,
   parameter int unsigned DW        = DW_DEF
) (
   input  logic                               clk,
   input  logic                               resetn,
   input  logic [SEL_W-1:0]                   cpu_sel,
   input  logic                               cpu_req,
   input  logic                               cpu_wr,
   input  logic [1:0]                         cpu_size,
   input  logic [AW-1:0]                      cpu_addr,
   input  logic [DW-1:0]                      cpu_wdata,
   output logic [DW-1:0]                      cpu_rdata,
   output logic                               cpu_addr_ok,
   output logic                               cpu_data_ok,
   output logic [N_SLV-1:0]                   s_req,
   output logic [N_SLV-1:0]                   s_wr,
   output logic [2*N_SLV-1:0]                 s_size,
   output logic [AW*N_SLV-1:0]                s_addr,
   output logic [DW*N_SLV-1:0]                s_wdata,
   input  logic [DW*N_SLV-1:0]                s_rdata,
   input  logic [N_SLV-1:0]                   s_addr_ok,
   input  logic [N_SLV-1:0]                   s_data_ok,
   output logic [$clog2(MAX_OUTST+1)-1:0]     outst_cnt,
   output logic                               err_stray
);

   logic [SEL_W-1:0] head;
   logic [SEL_W-1:0] last;
   logic             full;
   logic             empty;
   logic [N_SLV-1:0] sel_oh;
   logic [N_SLV-1:0] head_oh;
   logic             go;
   logic             stray;

   // One-hot decode of target and of the slave owed the next response; out-of-range sel decodes to none.
   always_comb begin
      sel_oh  = '0;
      head_oh = '0;
      for (int j = 0; j < N_SLV; j++) begin
         sel_oh[j]  = resetn && (cpu_sel == SEL_W'(j));
         head_oh[j] = !empty && (head == SEL_W'(j));
      end
   end

   // Switching slaves waits for the pipe to drain so responses cannot reorder.
   assign go          = cpu_req & (|sel_oh) & ~full & (empty | (cpu_sel == last));
   assign cpu_addr_ok = go & (|(sel_oh & s_addr_ok));
   assign cpu_data_ok = |(head_oh & s_data_ok);
   assign stray       = |(s_data_ok & ~head_oh);

   always_comb begin
      s_req     = '0;
      s_wr      = '0;
      s_size    = '0;
      s_addr    = '0;
      s_wdata   = '0;
      cpu_rdata = '0;
      for (int j = 0; j < N_SLV; j++) begin
         s_req[j] = go & sel_oh[j];
         s_wr[j]  = cpu_wr & sel_oh[j];
         if (sel_oh[j]) begin
            s_size[2*j +: 2]   = cpu_size;
            s_addr[AW*j +: AW] = cpu_addr;
            s_wdata[DW*j +: DW] = cpu_wdata;
         end
         if (head_oh[j]) cpu_rdata = s_rdata[DW*j +: DW];
      end
   end

   bridge_id_fifo #(
      .WIDTH (SEL_W),
      .DEPTH (MAX_OUTST)
   ) u_id_fifo (
      .clk    (clk),
      .resetn (resetn),
      .push   (cpu_addr_ok),
      .pop    (cpu_data_ok),
      .din    (cpu_sel),
      .head   (head),
      .last   (last),
      .full   (full),
      .empty  (empty),
      .count  (outst_cnt)
   );

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) err_stray <= 1'b0;
      else         err_stray <= stray;
   end

endmodule
